// File: rtl/encoder_16to4_if.sv
// Request/index bundle between one-hot producers and the binary encoder.
// The master modport drives the request vector and the slave modport returns the registered index, valid and err flags.
interface encoder_16to4_if #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 4
);
   logic [IN_W-1:0]  In;
   logic [OUT_W-1:0] X;
   logic             valid;
   logic             err;

   modport master (output In, input X, valid, err);
   modport slave  (input In, output X, valid, err);
endinterface

// File: rtl/encoder_16to4.sv
// Registered one-hot to binary encoder with highest-weight priority on multi-hot inputs.
// valid flags any set bit; err flags two or more set bits.
module encoder_16to4 #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   encoder_16to4_if.slave bus
);

   generate
      if (OUT_W != $clog2(IN_W)) begin : g_bad_width
         $error("encoder_16to4: OUT_W must equal clog2(IN_W)");
      end
   endgenerate

   logic [OUT_W-1:0] x_d, x_q;
   logic             valid_d, valid_q;
   logic             err_d, err_q;
   logic [IN_W-1:0]  in_minus_one;

   always_comb begin
      x_d          = '0;
      in_minus_one = bus.In - IN_W'(1);
      valid_d      = |bus.In;
      err_d        = |(bus.In & in_minus_one);
      // Ascending scan: the last hit is the highest set bit, giving priority by weight.
      for (int unsigned i = 0; i < IN_W; i++) begin
         if (bus.In[i]) begin
            x_d = OUT_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q     <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         x_q     <= x_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign bus.X     = x_q;
   assign bus.valid = valid_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_encoder_16to4.sv
// Directed-vector bench for encoder_16to4 with hand-computed expected values.
module tb_encoder_16to4;

   logic clk;
   logic rst;
   int unsigned n_checks;
   int unsigned n_pass;

   encoder_16to4_if #(.IN_W(16), .OUT_W(4)) bus ();

   encoder_16to4 #(.IN_W(16), .OUT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_checks++;
      if (obs === exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Drive at the falling edge; check 1 time unit after the next rising edge.
   task automatic apply(input logic [15:0] in_v, input logic r,
                        input logic [3:0] ex, input logic ev, input logic ee,
                        input string tag);
      @(negedge clk);
      bus.In = in_v;
      rst    = r;
      @(posedge clk);
      #1;
      check({tag, ".X"},     {12'h000, bus.X},     {12'h000, ex});
      check({tag, ".valid"}, {15'h0000, bus.valid}, {15'h0000, ev});
      check({tag, ".err"},   {15'h0000, bus.err},   {15'h0000, ee});
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      bus.In   = 16'hFFFF;

      apply(16'hFFFF, 1'b1, 4'd0, 1'b0, 1'b0, "reset0");
      apply(16'hFFFF, 1'b1, 4'd0, 1'b0, 1'b0, "reset1");

      for (int k = 0; k < 16; k++) begin
         apply(16'h0001 << k, 1'b0, 4'(k), 1'b1, 1'b0, $sformatf("walk%0d", k));
      end

      apply(16'h0000, 1'b0, 4'd0,  1'b0, 1'b0, "zero");
      apply(16'h0081, 1'b0, 4'd7,  1'b1, 1'b1, "multi_0081");
      apply(16'hFFFF, 1'b0, 4'd15, 1'b1, 1'b1, "multi_ffff");
      apply(16'h0003, 1'b0, 4'd1,  1'b1, 1'b1, "multi_0003");
      apply(16'h8000, 1'b0, 4'd15, 1'b1, 1'b0, "single_8000");
      apply(16'hC000, 1'b0, 4'd15, 1'b1, 1'b1, "multi_c000");
      apply(16'h0000, 1'b0, 4'd0,  1'b0, 1'b0, "zero_again");

      apply(16'h0400, 1'b1, 4'd0,  1'b0, 1'b0, "midrst_on");
      apply(16'h0400, 1'b0, 4'd10, 1'b1, 1'b0, "midrst_off");

      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) apply(16'h0002, 1'b0, 4'd1,  1'b1, 1'b0, $sformatf("alt%0d", i));
         else            apply(16'h2000, 1'b0, 4'd13, 1'b1, 1'b0, $sformatf("alt%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
